// File: rtl/tl45_decode_pkg.sv
// Shared decode definitions for the TL45 decode stage: instruction field
// positions, opcode and mode constants, pipeline state type and the
// instruction legality check used by the combinational decoder.
package tl45_decode_pkg;

    localparam int OPCODE_HI  = 31;
    localparam int OPCODE_LO  = 27;
    localparam int RI_BIT     = 26;
    localparam int LH_BIT     = 25;
    localparam int ZS_BIT     = 24;
    localparam int DR_HI      = 23;
    localparam int DR_LO      = 20;
    localparam int SR1_HI     = 19;
    localparam int SR1_LO     = 16;
    localparam int SR2_HI     = 15;
    localparam int SR2_LO     = 12;
    localparam int IMM_HI     = 15;
    localparam int IMM_LO     = 0;
    localparam int LOW_IMM_HI = 11;
    localparam int LOW_IMM_LO = 0;

    localparam logic [4:0] OP_00 = 5'h00;
    localparam logic [4:0] OP_01 = 5'h01;
    localparam logic [4:0] OP_02 = 5'h02;
    localparam logic [4:0] OP_05 = 5'h05;
    localparam logic [4:0] OP_06 = 5'h06;
    localparam logic [4:0] OP_07 = 5'h07;
    localparam logic [4:0] OP_08 = 5'h08;
    localparam logic [4:0] OP_09 = 5'h09;
    localparam logic [4:0] OP_0C = 5'h0C;
    localparam logic [4:0] OP_0D = 5'h0D;
    localparam logic [4:0] OP_0E = 5'h0E;
    localparam logic [4:0] OP_10 = 5'h10;
    localparam logic [4:0] OP_11 = 5'h11;
    localparam logic [4:0] OP_14 = 5'h14;
    localparam logic [4:0] OP_15 = 5'h15;

    // mode = {ri, lh, zs}
    localparam logic [2:0] MODE_REG = 3'b000;
    localparam logic [2:0] MODE_ZS  = 3'b001;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    // Returns 1 when the instruction word encodes a legal operation.
    function automatic logic inst_legal(input logic [31:0] inst);
        logic [4:0]  op;
        logic [2:0]  mode;
        logic        reg_form_clean;
        logic        ok;
        op             = inst[OPCODE_HI:OPCODE_LO];
        mode           = {inst[RI_BIT], inst[LH_BIT], inst[ZS_BIT]};
        reg_form_clean = (mode == MODE_REG) && (inst[LOW_IMM_HI:LOW_IMM_LO] == 12'h000);
        ok             = 1'b0;
        case (op)
            OP_00:                             ok = (inst == 32'h0000_0000);
            OP_01, OP_02, OP_05, OP_06,
            OP_07, OP_08:                      ok = inst[RI_BIT] || reg_form_clean;
            OP_09:                             ok = reg_form_clean;
            OP_0C, OP_0D, OP_14, OP_15:        ok = (mode == MODE_ZS);
            OP_0E:                             ok = (mode == MODE_REG)
                                                    && (inst[DR_HI:DR_LO] == 4'hF)
                                                    && (inst[SR1_HI:SR1_LO] == 4'h0)
                                                    && (inst[IMM_HI:IMM_LO] == 16'h0000);
            OP_10:                             ok = (mode == MODE_REG) && (inst[SR1_HI:SR1_LO] == 4'h0);
            OP_11:                             ok = (mode == MODE_REG) && (inst[DR_HI:DR_LO] == 4'h0);
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tl45_decode_comb.sv
// Purely combinational TL45 decoder: splits the instruction into fields,
// resolves the immediate and reports whether the word is legal.
module tl45_decode_comb
    import tl45_decode_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [31:0]      inst,
    output logic [4:0]       opcode,
    output logic             ri,
    output logic [REG_W-1:0] dr,
    output logic [REG_W-1:0] sr1,
    output logic [REG_W-1:0] sr2,
    output logic [31:0]      imm,
    output logic             legal
);

    logic [15:0] raw_imm;
    logic [31:0] resolved_imm;

    // Field split, immediate resolution and legality of the incoming word.
    always_comb begin
        opcode  = inst[OPCODE_HI:OPCODE_LO];
        ri      = inst[RI_BIT];
        raw_imm = inst[IMM_HI:IMM_LO];
        if (inst[LH_BIT]) begin
            resolved_imm = {raw_imm, 16'h0000};
        end else if (inst[ZS_BIT]) begin
            resolved_imm = {{16{raw_imm[15]}}, raw_imm};
        end else begin
            resolved_imm = {16'h0000, raw_imm};
        end
        dr    = REG_W'(inst[DR_HI:DR_LO]);
        sr1   = REG_W'(inst[SR1_HI:SR1_LO]);
        sr2   = ri ? '0 : REG_W'(inst[SR2_HI:SR2_LO]);
        imm   = ri ? resolved_imm : 32'h0000_0000;
        legal = inst_legal(inst);
    end

endmodule

// File: rtl/tl45_decode_pipe.sv
// TL45 decode stage: combinational decode feeding an output register with a
// one-entry skid buffer, plus a RUN/TRAP controller that halts intake on an
// illegal instruction when TRAP_ON_ERR is set.
module tl45_decode_pipe
    import tl45_decode_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int REG_W       = 4,
    parameter int TRAP_ON_ERR = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [31:0]      i_inst,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [PC_W-1:0]  o_pc,
    output logic [4:0]       o_opcode,
    output logic             o_ri,
    output logic [REG_W-1:0] o_dr,
    output logic [REG_W-1:0] o_sr1,
    output logic [REG_W-1:0] o_sr2,
    output logic [31:0]      o_imm,
    output logic             o_decode_err,
    output logic             o_trap,
    output logic [PC_W-1:0]  o_trap_pc,
    input  logic             i_trap_ack
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [4:0]       opcode;
        logic             ri;
        logic [REG_W-1:0] dr;
        logic [REG_W-1:0] sr1;
        logic [REG_W-1:0] sr2;
        logic [31:0]      imm;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    entry_t          dec_entry;
    logic            dec_legal;
    entry_t          out_q, out_d;
    entry_t          skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [PC_W-1:0] trap_pc_q, trap_pc_d;
    state_t          state_q, state_d;

    logic accept;
    logic drain;
    logic take_legal;
    logic take_bad;

    assign dec_entry.pc = i_pc;

    tl45_decode_comb #(
        .REG_W (REG_W)
    ) u_comb (
        .inst   (i_inst),
        .opcode (dec_entry.opcode),
        .ri     (dec_entry.ri),
        .dr     (dec_entry.dr),
        .sr1    (dec_entry.sr1),
        .sr2    (dec_entry.sr2),
        .imm    (dec_entry.imm),
        .legal  (dec_legal)
    );

    assign accept     = i_valid && ready_q;
    assign drain      = out_valid_q && i_ready;
    assign take_legal = accept && dec_legal;
    assign take_bad   = accept && !dec_legal;

    // Next contents of the output register and skid buffer, in program order.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        err_d        = 1'b0;
        trap_pc_d    = trap_pc_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (!out_valid_q || drain) begin
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = take_legal;
                    if (take_legal) begin
                        skid_d = dec_entry;
                    end
                end else begin
                    out_valid_d = take_legal;
                    if (take_legal) begin
                        out_d = dec_entry;
                    end
                end
            end else if (take_legal) begin
                skid_d       = dec_entry;
                skid_valid_d = 1'b1;
            end
            err_d = take_bad;
            if (take_bad && (TRAP_ON_ERR != 0)) begin
                trap_pc_d = i_pc;
            end
        end
    end

    // RUN/TRAP next-state selection and the registered intake-ready decision.
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = ST_RUN;
        end else if (i_trap_ack) begin
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && take_bad && (TRAP_ON_ERR != 0)) begin
            state_d = ST_TRAP;
        end
        ready_d = (state_d == ST_RUN) && !skid_valid_d;
    end

    // Controller state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pipeline registers, error pulse and trap PC.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_q        <= ENTRY_ZERO;
            out_valid_q  <= 1'b0;
            skid_q       <= ENTRY_ZERO;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
            trap_pc_q    <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            trap_pc_q    <= trap_pc_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = out_valid_q;
    assign o_pc         = out_q.pc;
    assign o_opcode     = out_q.opcode;
    assign o_ri         = out_q.ri;
    assign o_dr         = out_q.dr;
    assign o_sr1        = out_q.sr1;
    assign o_sr2        = out_q.sr2;
    assign o_imm        = out_q.imm;
    assign o_decode_err = err_q;
    assign o_trap       = (state_q == ST_TRAP);
    assign o_trap_pc    = trap_pc_q;

endmodule

// File: tb/tb_tl45_decode_pipe.sv
// Directed testbench for tl45_decode_pipe: one trapping instance and one
// drop-on-error instance share the same stimulus.
module tb_tl45_decode_pipe;

    localparam int PC_W  = 32;
    localparam int REG_W = 4;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_flush;
    logic             i_valid;
    logic [PC_W-1:0]  i_pc;
    logic [31:0]      i_inst;
    logic             i_ready;
    logic             i_trap_ack;

    logic             o_ready, o_valid, o_ri, o_decode_err, o_trap;
    logic [PC_W-1:0]  o_pc, o_trap_pc;
    logic [4:0]       o_opcode;
    logic [REG_W-1:0] o_dr, o_sr1, o_sr2;
    logic [31:0]      o_imm;

    logic             nt_ready, nt_valid, nt_ri, nt_decode_err, nt_trap;
    logic [PC_W-1:0]  nt_pc, nt_trap_pc;
    logic [4:0]       nt_opcode;
    logic [REG_W-1:0] nt_dr, nt_sr1, nt_sr2;
    logic [31:0]      nt_imm;

    int checks;
    int errors;

    localparam logic [31:0] LEGAL_REG = 32'h0832_1000;

    tl45_decode_pipe #(.PC_W(PC_W), .REG_W(REG_W), .TRAP_ON_ERR(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_pc(i_pc), .i_inst(i_inst), .o_valid(o_valid),
        .i_ready(i_ready), .o_pc(o_pc), .o_opcode(o_opcode), .o_ri(o_ri),
        .o_dr(o_dr), .o_sr1(o_sr1), .o_sr2(o_sr2), .o_imm(o_imm),
        .o_decode_err(o_decode_err), .o_trap(o_trap), .o_trap_pc(o_trap_pc),
        .i_trap_ack(i_trap_ack)
    );

    tl45_decode_pipe #(.PC_W(PC_W), .REG_W(REG_W), .TRAP_ON_ERR(0)) dut_nt (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(nt_ready), .i_pc(i_pc), .i_inst(i_inst), .o_valid(nt_valid),
        .i_ready(i_ready), .o_pc(nt_pc), .o_opcode(nt_opcode), .o_ri(nt_ri),
        .o_dr(nt_dr), .o_sr1(nt_sr1), .o_sr2(nt_sr2), .o_imm(nt_imm),
        .o_decode_err(nt_decode_err), .o_trap(nt_trap), .o_trap_pc(nt_trap_pc),
        .i_trap_ack(i_trap_ack)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    // Drive one cycle's worth of inputs; they take effect at the next edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic rdy, input logic fl, input logic ack);
        i_valid    = v;
        i_pc       = pc;
        i_inst     = inst;
        i_ready    = rdy;
        i_flush    = fl;
        i_trap_ack = ack;
    endtask

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] timeout");
    end

    // Directed test sequence.
    initial begin
        checks = 0;
        errors = 0;
        i_reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_valid",   64'(o_valid),      64'd0);
        checkOutput("rst_ready",   64'(o_ready),      64'd1);
        checkOutput("rst_trap",    64'(o_trap),       64'd0);
        checkOutput("rst_err",     64'(o_decode_err), 64'd0);
        checkOutput("rst_pc",      64'(o_pc),         64'd0);
        checkOutput("rst_imm",     64'(o_imm),        64'd0);
        checkOutput("rst_dr",      64'(o_dr),         64'd0);
        checkOutput("rst_trap_pc", 64'(o_trap_pc),    64'd0);
        i_reset = 1'b0;

        $display("[TB] basic decode");
        applyStimulus(1'b1, 32'h10, 32'h0D32_FFFE, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("d1_valid",  64'(o_valid),  64'd1);
        checkOutput("d1_pc",     64'(o_pc),     64'h10);
        checkOutput("d1_opcode", 64'(o_opcode), 64'd1);
        checkOutput("d1_ri",     64'(o_ri),     64'd1);
        checkOutput("d1_dr",     64'(o_dr),     64'd3);
        checkOutput("d1_sr1",    64'(o_sr1),    64'd2);
        checkOutput("d1_sr2",    64'(o_sr2),    64'd0);
        checkOutput("d1_imm",    64'(o_imm),    64'hFFFF_FFFE);
        applyStimulus(1'b1, 32'h14, 32'h0E10_1234, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("d2_pc",    64'(o_pc),    64'h14);
        checkOutput("d2_imm",   64'(o_imm),   64'h1234_0000);
        checkOutput("d2_ready", 64'(o_ready), 64'd1);
        applyStimulus(1'b1, 32'h18, LEGAL_REG, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("d3_pc",  64'(o_pc),  64'h18);
        checkOutput("d3_ri",  64'(o_ri),  64'd0);
        checkOutput("d3_sr2", 64'(o_sr2), 64'd1);
        checkOutput("d3_imm", 64'(o_imm), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("d4_drained", 64'(o_valid), 64'd0);

        $display("[TB] illegal low_imm");
        applyStimulus(1'b1, 32'h1C, 32'h0832_1001, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("i1_valid",    64'(o_valid),       64'd0);
        checkOutput("i1_err",      64'(o_decode_err),  64'd1);
        checkOutput("i1_trap",     64'(o_trap),        64'd1);
        checkOutput("i1_trap_pc",  64'(o_trap_pc),     64'h1C);
        checkOutput("i1_ready",    64'(o_ready),       64'd0);
        checkOutput("i1_nt_err",   64'(nt_decode_err), 64'd1);
        checkOutput("i1_nt_valid", 64'(nt_valid),      64'd0);
        checkOutput("i1_nt_trap",  64'(nt_trap),       64'd0);
        checkOutput("i1_nt_ready", 64'(nt_ready),      64'd1);
        applyStimulus(1'b1, 32'h20, 32'h0D32_FFFE, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("i2_err_pulse", 64'(o_decode_err), 64'd0);
        checkOutput("i2_blocked",   64'(o_valid),      64'd0);
        checkOutput("i2_ready",     64'(o_ready),      64'd0);
        checkOutput("i2_trap",      64'(o_trap),       64'd1);
        checkOutput("i2_nt_valid",  64'(nt_valid),     64'd1);
        checkOutput("i2_nt_pc",     64'(nt_pc),        64'h20);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("i3_trap",    64'(o_trap),    64'd0);
        checkOutput("i3_ready",   64'(o_ready),   64'd1);
        checkOutput("i3_trap_pc", 64'(o_trap_pc), 64'h1C);

        $display("[TB] illegal opcode trap");
        applyStimulus(1'b1, 32'h40, 32'hF800_0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t1_trap",     64'(o_trap),        64'd1);
        checkOutput("t1_trap_pc",  64'(o_trap_pc),     64'h40);
        checkOutput("t1_err",      64'(o_decode_err),  64'd1);
        checkOutput("t1_ready",    64'(o_ready),       64'd0);
        checkOutput("t1_nt_err",   64'(nt_decode_err), 64'd1);
        checkOutput("t1_nt_ready", 64'(nt_ready),      64'd1);
        checkOutput("t1_nt_trap",  64'(nt_trap),       64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
        end
        checkOutput("t2_ready",  64'(o_ready),       64'd0);
        checkOutput("t2_trap",   64'(o_trap),        64'd1);
        checkOutput("t2_nt_err", 64'(nt_decode_err), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("t3_trap",  64'(o_trap),  64'd0);
        checkOutput("t3_ready", 64'(o_ready), 64'd1);

        $display("[TB] skid ordering");
        applyStimulus(1'b1, 32'h0, LEGAL_REG, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("s1_valid", 64'(o_valid), 64'd1);
        checkOutput("s1_pc",    64'(o_pc),    64'h0);
        checkOutput("s1_ready", 64'(o_ready), 64'd1);
        applyStimulus(1'b1, 32'h4, LEGAL_REG, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("s2_pc",    64'(o_pc),    64'h0);
        checkOutput("s2_ready", 64'(o_ready), 64'd0);
        applyStimulus(1'b1, 32'h8, LEGAL_REG, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("s3_pc",    64'(o_pc),    64'h0);
        checkOutput("s3_valid", 64'(o_valid), 64'd1);
        checkOutput("s3_ready", 64'(o_ready), 64'd0);
        applyStimulus(1'b1, 32'h8, LEGAL_REG, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("s4_pc",    64'(o_pc),    64'h4);
        checkOutput("s4_ready", 64'(o_ready), 64'd1);
        tick();
        checkOutput("s5_pc",    64'(o_pc),    64'h8);
        checkOutput("s5_valid", 64'(o_valid), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("s6_valid", 64'(o_valid), 64'd0);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h100, LEGAL_REG, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h104, LEGAL_REG, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("f1_ready", 64'(o_ready), 64'd0);
        applyStimulus(1'b1, 32'h108, LEGAL_REG, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("f2_valid", 64'(o_valid), 64'd0);
        checkOutput("f2_ready", 64'(o_ready), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("f3_skid_gone", 64'(o_valid), 64'd0);
        applyStimulus(1'b1, 32'h200, LEGAL_REG, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("f4_pc", 64'(o_pc), 64'h200);
        applyStimulus(1'b1, 32'h204, LEGAL_REG, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("f5_valid", 64'(o_valid), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("f6_valid", 64'(o_valid), 64'd0);
        checkOutput("f6_ready", 64'(o_ready), 64'd1);
        applyStimulus(1'b1, 32'h300, 32'hF800_0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("f7_trap", 64'(o_trap), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("f8_trap",    64'(o_trap),    64'd0);
        checkOutput("f8_ready",   64'(o_ready),   64'd1);
        checkOutput("f8_trap_pc", 64'(o_trap_pc), 64'h300);

        $display("[TB] opcode boundaries");
        applyStimulus(1'b1, 32'h380, 32'h6123_4567, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("b1_valid",  64'(o_valid),  64'd1);
        checkOutput("b1_opcode", 64'(o_opcode), 64'h0C);
        checkOutput("b1_sr2",    64'(o_sr2),    64'd4);
        checkOutput("b1_imm",    64'(o_imm),    64'd0);
        applyStimulus(1'b1, 32'h400, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("b2_valid",  64'(o_valid),      64'd1);
        checkOutput("b2_pc",     64'(o_pc),         64'h400);
        checkOutput("b2_opcode", 64'(o_opcode),     64'd0);
        checkOutput("b2_err",    64'(o_decode_err), 64'd0);
        applyStimulus(1'b1, 32'h404, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("b3_valid", 64'(o_valid),      64'd0);
        checkOutput("b3_err",   64'(o_decode_err), 64'd1);
        checkOutput("b3_trap",  64'(o_trap),       64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("b4_trap", 64'(o_trap), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl45_decode_pipe.md
TL45_DECODE_PIPE -- requirements
Module: tl45_decode_pipe

Interface
REQ-001 Parameter PC_W, default 32, width of the PC path.
REQ-002 Parameter REG_W, default 4, width of register-index fields.
REQ-003 Parameter TRAP_ON_ERR, default 1; 1 = illegal instruction halts intake (trap), 0 = illegal instruction dropped with error pulse.
REQ-004 Ports SHALL be exactly:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_flush  in  1  discard all buffered and in-flight instructions
i_valid  in  1  upstream instruction valid
o_ready  out  1  decoder accepts this cycle
i_pc  in  PC_W  instruction PC
i_inst  in  32  instruction word
o_valid  out  1  decoded output valid
i_ready  in  1  downstream accepts
o_pc  out  PC_W  PC of decoded instruction
o_opcode  out  5  opcode
o_ri  out  1  immediate form
o_dr, o_sr1, o_sr2  out  REG_W  register indices
o_imm  out  32  resolved immediate
o_decode_err  out  1  one-cycle pulse per illegal instruction
o_trap  out  1  decoder halted on illegal instruction
o_trap_pc  out  PC_W  PC of trapping instruction
i_trap_ack  in  1  release trap
REQ-005 Clock i_clk; reset i_reset, synchronous, active-high.

Function
REQ-006 Fields: opcode[31:27], ri[26], lh[25], zs[24], dr[23:20], sr1[19:16], sr2[15:12], imm[15:0], low_imm[11:0].
REQ-007 Immediate: lh=1 -> {imm,16'h0}; lh=0,zs=1 -> sign-extended imm; lh=0,zs=0 -> zero-extended imm.
REQ-008 Legality: 0x00 legal only if inst==0; 0x01,02,05-08 legal if ri=1, or mode==0 and low_imm==0; 0x09 mode==0 and low_imm==0; 0x0C,0x0D mode==3'b001; 0x0E mode==0, dr==4'hF, sr1==0, imm==0; 0x10 mode==0, sr1==0; 0x11 mode==0, dr==0; 0x14,0x15 mode==3'b001; all other opcodes illegal (mode={ri,lh,zs}).
REQ-009 Legal decode: o_sr2 = ri ? 0 : sr2; o_imm = ri ? resolved : 0.
REQ-010 Handshake: transfer in on i_valid&&o_ready; transfer out on o_valid&&i_ready; o_valid and payload SHALL hold stable until transferred.
REQ-011 Latency: accepted legal instruction SHALL appear on o_valid the next cycle when output register is empty or being drained.
REQ-012 One-entry skid buffer: if output is held, accepted instruction SHALL go to skid; o_ready SHALL be a registered signal, low while skid is full; program order SHALL be preserved; full throughput (1/cycle) with i_ready=1.
REQ-013 States RUN, TRAP. In RUN with TRAP_ON_ERR=1, accepted illegal instruction SHALL: not be emitted, pulse o_decode_err, latch o_trap_pc, enter TRAP next cycle.
REQ-014 In TRAP: o_trap=1, o_ready=0; previously accepted instructions SHALL still drain; i_trap_ack SHALL return to RUN next cycle.
REQ-015 TRAP_ON_ERR=0: illegal instruction SHALL be dropped, o_decode_err pulsed, state stays RUN.
REQ-016 i_flush SHALL clear o_valid and skid next cycle, ignore any same-cycle input transfer, and return to RUN; o_trap_pc retained.
REQ-017 Priority: i_reset > i_flush > i_trap_ack > normal operation.

Reset
REQ-018 On reset: o_valid=0, skid empty, o_ready=1 next cycle, state RUN, o_trap=0, o_decode_err=0; all payload outputs and o_trap_pc zero.

Structure
REQ-019 Package tl45_decode_pkg SHALL hold the opcode constants, field bit positions, mode constants and a legality function.
REQ-020 Combinational field split/legality/immediate logic SHALL be sub-module tl45_decode_comb; skid buffer and FSM remain in the top.

Verification
REQ-021 i_inst=0x0D32FFFE, i_ready=1 -> next cycle o_opcode=1, o_ri=1, o_dr=3, o_sr1=2, o_sr2=0, o_imm=0xFFFFFFFE.
REQ-022 i_inst=0x0E101234 -> o_imm=0x12340000; i_inst=0x08321000 -> o_sr2=1, o_imm=0; i_inst=0x08321001 -> o_decode_err pulse, no o_valid.
REQ-023 i_inst=0xF8000000, i_pc=0x40, TRAP_ON_ERR=1 -> o_trap=1, o_trap_pc=0x40, o_ready=0 until i_trap_ack; TRAP_ON_ERR=0 -> pulse only, o_ready stays 1.
REQ-024 Stream PCs 0x0,0x4,0x8 with i_ready=0 for 3 cycles -> o_ready low after two accepted, outputs emerge 0x0,0x4,0x8 in order once i_ready=1.
REQ-025 i_flush with output and skid full and i_valid=1 -> o_valid=0 next cycle, flushed-cycle instruction never emitted.
